// File: rtl/des_req_arbiter_if.sv
// Requester / DES-core / response bundle for des_req_arbiter.
//   master : arbiter side (accepts requests, drives the core, returns responses)
//   slave  : environment side (requesters, DES core, response consumer)
// Ports:
//   req_*   per-requester valid/data/key/mode/verify in, one-hot ready out
//   des_*   core data/key/mode/verify/encrypt-valid out, ready/result/result-valid in
//   rsp_*   response valid/id/data/err out, ready in
interface des_req_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid_in;
    logic [N_REQ*64-1:0] req_data_in;
    logic [N_REQ*64-1:0] req_key_in;
    logic [N_REQ-1:0]    req_mode_in;
    logic [N_REQ-1:0]    req_verify_in;
    logic [N_REQ-1:0]    req_ready_out;

    logic [63:0]         des_data_out;
    logic [63:0]         des_key_out;
    logic                des_mode_out;
    logic                des_verify_out;
    logic                des_encrypt_valid_out;
    logic                des_encrypt_ready_in;
    logic [63:0]         des_result_in;
    logic                des_result_valid_in;

    logic                rsp_valid_out;
    logic                rsp_ready_in;
    logic [ID_W-1:0]     rsp_id_out;
    logic [63:0]         rsp_data_out;
    logic                rsp_err_out;

    modport master (
        input  req_valid_in, req_data_in, req_key_in, req_mode_in, req_verify_in,
        output req_ready_out,
        output des_data_out, des_key_out, des_mode_out, des_verify_out, des_encrypt_valid_out,
        input  des_encrypt_ready_in, des_result_in, des_result_valid_in,
        output rsp_valid_out, rsp_id_out, rsp_data_out, rsp_err_out,
        input  rsp_ready_in
    );

    modport slave (
        output req_valid_in, req_data_in, req_key_in, req_mode_in, req_verify_in,
        input  req_ready_out,
        input  des_data_out, des_key_out, des_mode_out, des_verify_out, des_encrypt_valid_out,
        output des_encrypt_ready_in, des_result_in, des_result_valid_in,
        input  rsp_valid_out, rsp_id_out, rsp_data_out, rsp_err_out,
        output rsp_ready_in
    );
endinterface

// File: rtl/des_req_arbiter.sv
// Round-robin arbiter sharing one DES core among N_REQ requesters.
// One job in flight: grant -> issue -> wait for result (with timeout) -> respond.
// Ports:
//   clk_in  : clock, rising edge
//   rst_in  : asynchronous active-high reset
//   io_bus  : des_req_arbiter_if.master (requester, core and response signals)
module des_req_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic               clk_in,
    input logic               rst_in,
    des_req_arbiter_if.master io_bus
);
    localparam int unsigned BLK_W = 64;
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam int unsigned DK_W  = $clog2(N_REQ * BLK_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_last_grant, w_last_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [BLK_W-1:0]   r_des_data, w_des_data_nxt;
    logic [BLK_W-1:0]   r_des_key, w_des_key_nxt;
    logic               r_des_mode, w_des_mode_nxt;
    logic               r_des_verify, w_des_verify_nxt;
    logic [ID_W-1:0]    r_rsp_id, w_rsp_id_nxt;
    logic [BLK_W-1:0]   r_rsp_data, w_rsp_data_nxt;
    logic               r_rsp_err, w_rsp_err_nxt;

    logic               w_found;
    logic [ID_W-1:0]    w_cand;
    logic [ID_W-1:0]    w_gidx;
    logic [BLK_W-1:0]   w_sel_data;
    logic [BLK_W-1:0]   w_sel_key;
    logic               w_sel_mode;
    logic               w_sel_verify;
    logic [N_REQ-1:0]   w_req_ready;

    // Round-robin pick: first valid requester after the last grant, wrapping.
    always_comb begin : rr_pick
        w_found      = 1'b0;
        w_cand       = '0;
        w_gidx       = '0;
        w_sel_data   = '0;
        w_sel_key    = '0;
        w_sel_mode   = 1'b0;
        w_sel_verify = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_cand = ID_W'((32'(r_last_grant) + k) % N_REQ);
            if (!w_found && io_bus.req_valid_in[w_cand]) begin
                w_found      = 1'b1;
                w_gidx       = w_cand;
                w_sel_data   = io_bus.req_data_in[DK_W'(BLK_W * 32'(w_cand)) +: BLK_W];
                w_sel_key    = io_bus.req_key_in[DK_W'(BLK_W * 32'(w_cand)) +: BLK_W];
                w_sel_mode   = io_bus.req_mode_in[w_cand];
                w_sel_verify = io_bus.req_verify_in[w_cand];
            end
        end
    end

    // Next-state and next-register values.
    always_comb begin : fsm_next
        w_state_nxt      = r_state;
        w_last_nxt       = r_last_grant;
        w_cnt_nxt        = r_cnt;
        w_des_data_nxt   = r_des_data;
        w_des_key_nxt    = r_des_key;
        w_des_mode_nxt   = r_des_mode;
        w_des_verify_nxt = r_des_verify;
        w_rsp_id_nxt     = r_rsp_id;
        w_rsp_data_nxt   = r_rsp_data;
        w_rsp_err_nxt    = r_rsp_err;
        w_req_ready      = '0;

        case (r_state)
            S_IDLE: begin
                if (io_bus.des_encrypt_ready_in && w_found) begin
                    w_req_ready[w_gidx] = 1'b1;
                    w_last_nxt          = w_gidx;
                    w_des_data_nxt      = w_sel_data;
                    w_des_key_nxt       = w_sel_key;
                    w_des_mode_nxt      = w_sel_mode;
                    w_des_verify_nxt    = w_sel_verify;
                    w_state_nxt         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the final wait cycle still beats the timeout.
                if (io_bus.des_result_valid_in) begin
                    w_rsp_id_nxt   = r_last_grant;
                    w_rsp_data_nxt = io_bus.des_result_in;
                    w_rsp_err_nxt  = 1'b0;
                    w_state_nxt    = S_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_rsp_id_nxt   = r_last_grant;
                    w_rsp_data_nxt = '0;
                    w_rsp_err_nxt  = 1'b1;
                    w_state_nxt    = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (io_bus.rsp_ready_in) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_cnt        <= '0;
            r_des_data   <= '0;
            r_des_key    <= '0;
            r_des_mode   <= 1'b0;
            r_des_verify <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            r_des_data   <= w_des_data_nxt;
            r_des_key    <= w_des_key_nxt;
            r_des_mode   <= w_des_mode_nxt;
            r_des_verify <= w_des_verify_nxt;
            r_rsp_id     <= w_rsp_id_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
        end
    end

    // Accept pulse is combinational; held low while reset is asserted.
    assign io_bus.req_ready_out         = rst_in ? '0 : w_req_ready;
    assign io_bus.des_data_out          = r_des_data;
    assign io_bus.des_key_out           = r_des_key;
    assign io_bus.des_mode_out          = r_des_mode;
    assign io_bus.des_verify_out        = r_des_verify;
    assign io_bus.des_encrypt_valid_out = (r_state == S_ISSUE);
    assign io_bus.rsp_valid_out         = (r_state == S_RESP);
    assign io_bus.rsp_id_out            = r_rsp_id;
    assign io_bus.rsp_data_out          = r_rsp_data;
    assign io_bus.rsp_err_out           = r_rsp_err;

endmodule

// File: tb/tb_des_req_arbiter.sv
// Bench for des_req_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level model of grants, issue timing and responses.
module tb_des_req_arbiter;
    localparam int unsigned N           = 4;
    localparam int unsigned TO          = 16;
    localparam int unsigned IDW         = $clog2(N);
    localparam int unsigned DKW         = $clog2(N * 64);
    localparam int          RAND_CYCLES = 3000;
    localparam int          NEVER       = 32'h7fff_ffff;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    des_req_arbiter_if #(.N_REQ(N)) bus ();

    des_req_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random-phase model state
    logic [63:0]  m_data [N];
    logic [63:0]  m_key  [N];
    logic         m_mode [N];
    logic         m_verify [N];
    logic [N-1:0] m_valid;
    logic [63:0]  j_data, j_key;
    logic         j_mode, j_verify;
    int           j_id;
    bit           busy, found, in_resp, core_rdy, rsp_rdy;
    int           enc_cyc, strobe_cyc, resp_start, last, win, idx, dly;
    logic [63:0]  res_val, exp_rdata;
    logic         exp_err;
    logic [N-1:0] exp_rr;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] d, input logic [63:0] k,
                           input logic m, input logic v);
        bus.req_data_in[DKW'(i * 64) +: 64] = d;
        bus.req_key_in[DKW'(i * 64) +: 64]  = k;
        bus.req_mode_in[IDW'(i)]            = m;
        bus.req_verify_in[IDW'(i)]          = v;
    endtask

    task automatic check_rsp(input string tag, input int id, input logic [63:0] d, input logic e);
        check({tag, "_valid"}, 64'(bus.rsp_valid_out), 64'(1));
        check({tag, "_id"},    64'(bus.rsp_id_out),    64'(id));
        check({tag, "_data"},  bus.rsp_data_out,       d);
        check({tag, "_err"},   64'(bus.rsp_err_out),   64'(e));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst                      = 1'b1;
        bus.req_valid_in         = '0;
        bus.req_data_in          = '0;
        bus.req_key_in           = '0;
        bus.req_mode_in          = '0;
        bus.req_verify_in        = '0;
        bus.des_encrypt_ready_in = 1'b1;
        bus.des_result_in        = '0;
        bus.des_result_valid_in  = 1'b0;
        bus.rsp_ready_in         = 1'b0;

        // Reset: outputs quiet even with requests pending and core ready
        bus.req_valid_in = 4'b1111;
        tick();
        tick();
        check("rst_ready",   64'(bus.req_ready_out),         64'(0));
        check("rst_enc",     64'(bus.des_encrypt_valid_out), 64'(0));
        check("rst_rsp",     64'(bus.rsp_valid_out),         64'(0));
        check("rst_rsp_id",  64'(bus.rsp_id_out),            64'(0));
        check("rst_desdata", bus.des_data_out,               64'(0));
        bus.req_valid_in = '0;
        rst = 1'b0;
        tick();

        // 1: single job from requester 0
        set_req(0, 64'h2e7033340f4917f8, {8{8'h54}}, 1'b1, 1'b1);
        bus.req_valid_in = 4'b0001;
        bus.rsp_ready_in = 1'b1;
        #1 check("t1_grant", 64'(bus.req_ready_out), 64'(4'b0001));
        tick();
        bus.req_valid_in = '0;
        check("t1_enc",    64'(bus.des_encrypt_valid_out), 64'(1));
        check("t1_data",   bus.des_data_out,               64'h2e7033340f4917f8);
        check("t1_key",    bus.des_key_out,                {8{8'h54}});
        check("t1_mode",   64'(bus.des_mode_out),          64'(1));
        check("t1_verify", 64'(bus.des_verify_out),        64'(1));
        tick();
        check("t1_enc_once", 64'(bus.des_encrypt_valid_out), 64'(0));
        check("t1_no_rsp",   64'(bus.rsp_valid_out),         64'(0));
        bus.des_result_in       = 64'ha5a5_0123_4567_89ab;
        bus.des_result_valid_in = 1'b1;
        tick();
        bus.des_result_valid_in = 1'b0;
        check_rsp("t1_rsp", 0, 64'ha5a5_0123_4567_89ab, 1'b0);
        tick();
        check("t1_rsp_drop", 64'(bus.rsp_valid_out), 64'(0));

        // 2: fairness from a fresh reset, all requesters valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++)
            set_req(i, 64'h0123_4567_89ab_cd00 + 64'(i), ~(64'h0123_4567_89ab_cd00 + 64'(i)),
                    1'(i), 1'(i >> 1));
        bus.req_valid_in = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            #1 check($sformatf("t2_grant%0d", j), 64'(bus.req_ready_out), 64'(4'b0001 << (j % 4)));
            tick();
            check($sformatf("t2_data%0d", j), bus.des_data_out, 64'h0123_4567_89ab_cd00 + 64'(j % 4));
            tick();
            bus.des_result_in       = 64'hfa00 + 64'(j);
            bus.des_result_valid_in = 1'b1;
            tick();
            bus.des_result_valid_in = 1'b0;
            check_rsp($sformatf("t2_rsp%0d", j), j % 4, 64'hfa00 + 64'(j), 1'b0);
            tick();
        end
        bus.req_valid_in = '0;

        // 3: timeout with the core never answering
        set_req(3, 64'h3333_0000_1111_2222, 64'h0f0f_0f0f_0f0f_0f0f, 1'b0, 1'b1);
        bus.req_valid_in = 4'b1000;
        bus.rsp_ready_in = 1'b0;
        #1 check("t3_grant", 64'(bus.req_ready_out), 64'(4'b1000));
        tick();
        bus.req_valid_in = '0;
        check("t3_enc", 64'(bus.des_encrypt_valid_out), 64'(1));
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("t3_wait%0d", k), 64'(bus.rsp_valid_out), 64'(0));
        end
        tick();
        check_rsp("t3_timeout", 3, 64'(0), 1'b1);
        bus.des_result_in       = 64'hdead_beef_dead_beef;
        bus.des_result_valid_in = 1'b1;
        tick();
        bus.des_result_valid_in = 1'b0;
        check_rsp("t3_late", 3, 64'(0), 1'b1);
        bus.rsp_ready_in = 1'b1;
        tick();
        check("t3_rsp_drop", 64'(bus.rsp_valid_out), 64'(0));
        bus.des_result_valid_in = 1'b1;
        tick();
        bus.des_result_valid_in = 1'b0;
        check("t3_stale1", 64'(bus.rsp_valid_out), 64'(0));
        tick();
        check("t3_stale2", 64'(bus.rsp_valid_out), 64'(0));

        // 4: response backpressure with another requester waiting
        set_req(0, 64'h4444_aaaa_5555_bbbb, 64'h1234_5678_9abc_def0, 1'b1, 1'b0);
        set_req(1, 64'h4141_4141_4141_4141, 64'h0000_ffff_0000_ffff, 1'b0, 1'b0);
        bus.req_valid_in = 4'b0011;
        bus.rsp_ready_in = 1'b0;
        #1 check("t4_grant0", 64'(bus.req_ready_out), 64'(4'b0001));
        tick();
        bus.req_valid_in = 4'b0010;
        check("t4_data0", bus.des_data_out, 64'h4444_aaaa_5555_bbbb);
        tick();
        bus.des_result_in       = 64'h0bad_cafe_0000_0004;
        bus.des_result_valid_in = 1'b1;
        tick();
        bus.des_result_valid_in = 1'b0;
        for (int b = 0; b < 10; b++) begin
            check_rsp($sformatf("t4_hold%0d", b), 0, 64'h0bad_cafe_0000_0004, 1'b0);
            check($sformatf("t4_noready%0d", b), 64'(bus.req_ready_out), 64'(0));
            tick();
        end
        bus.rsp_ready_in = 1'b1;
        #1 check_rsp("t4_hs", 0, 64'h0bad_cafe_0000_0004, 1'b0);
        tick();
        check("t4_rsp_drop", 64'(bus.rsp_valid_out), 64'(0));
        check("t4_grant1",   64'(bus.req_ready_out), 64'(4'b0010));
        tick();
        bus.req_valid_in = '0;
        check("t4_data1", bus.des_data_out, 64'h4141_4141_4141_4141);
        tick();
        bus.des_result_in       = 64'h0000_0000_0000_0041;
        bus.des_result_valid_in = 1'b1;
        tick();
        bus.des_result_valid_in = 1'b0;
        check_rsp("t4_rsp1", 1, 64'h0000_0000_0000_0041, 1'b0);
        tick();

        // 5: core busy blocks the grant
        bus.des_encrypt_ready_in = 1'b0;
        set_req(2, 64'h2222_2222_0000_5555, 64'h5555_0000_2222_2222, 1'b1, 1'b1);
        bus.req_valid_in = 4'b0100;
        for (int b = 0; b < 5; b++) begin
            #1 check($sformatf("t5_blocked%0d", b), 64'(bus.req_ready_out), 64'(0));
            tick();
        end
        bus.des_encrypt_ready_in = 1'b1;
        #1 check("t5_grant", 64'(bus.req_ready_out), 64'(4'b0100));
        tick();
        bus.req_valid_in = '0;
        check("t5_data", bus.des_data_out, 64'h2222_2222_0000_5555);
        tick();
        bus.des_result_in       = 64'h5555_5555_5555_5555;
        bus.des_result_valid_in = 1'b1;
        tick();
        bus.des_result_valid_in = 1'b0;
        check_rsp("t5_rsp", 2, 64'h5555_5555_5555_5555, 1'b0);
        tick();

        // 6: reset during WAIT
        set_req(3, 64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777, 1'b1, 1'b1);
        bus.req_valid_in = 4'b1000;
        #1 check("t6_grant", 64'(bus.req_ready_out), 64'(4'b1000));
        tick();
        bus.req_valid_in = '0;
        tick();
        tick();
        rst = 1'b1;
        bus.req_valid_in = 4'b1111;
        #1;
        check("t6_ready",  64'(bus.req_ready_out),         64'(0));
        check("t6_enc",    64'(bus.des_encrypt_valid_out), 64'(0));
        check("t6_data",   bus.des_data_out,               64'(0));
        check("t6_key",    bus.des_key_out,                64'(0));
        check("t6_mode",   64'(bus.des_mode_out),          64'(0));
        check("t6_verify", 64'(bus.des_verify_out),        64'(0));
        check("t6_rspv",   64'(bus.rsp_valid_out),         64'(0));
        check("t6_rspd",   bus.rsp_data_out,               64'(0));
        check("t6_rspe",   64'(bus.rsp_err_out),           64'(0));
        tick();
        bus.req_valid_in = '0;
        rst = 1'b0;
        bus.des_result_in       = 64'h0123_0123_0123_0123;
        bus.des_result_valid_in = 1'b1;
        tick();
        bus.des_result_valid_in = 1'b0;
        check("t6_stale1", 64'(bus.rsp_valid_out), 64'(0));
        tick();
        check("t6_stale2", 64'(bus.rsp_valid_out), 64'(0));
        set_req(0, 64'h0000_0000_0000_6060, 64'h0, 1'b0, 1'b0);
        bus.req_valid_in = 4'b1111;
        #1 check("t6_regrant", 64'(bus.req_ready_out), 64'(4'b0001));
        tick();
        bus.req_valid_in = '0;
        check("t6_data0", bus.des_data_out, 64'h0000_0000_0000_6060);
        tick();
        bus.des_result_in       = 64'h6060_6060_6060_6060;
        bus.des_result_valid_in = 1'b1;
        tick();
        bus.des_result_valid_in = 1'b0;
        check_rsp("t6_rsp", 0, 64'h6060_6060_6060_6060, 1'b0);
        tick();

        // Randomized run against the transaction model
        busy       = 1'b0;
        last       = 0;
        enc_cyc    = -1;
        strobe_cyc = -1;
        resp_start = NEVER;
        m_valid    = '0;
        res_val    = '0;
        exp_rdata  = '0;
        exp_err    = 1'b0;
        j_id       = 0;
        for (int i = 0; i < N; i++) begin
            m_data[i] = '0; m_key[i] = '0; m_mode[i] = 1'b0; m_verify[i] = 1'b0;
        end
        for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!m_valid[IDW'(i)] && $urandom_range(0, 3) == 0) begin
                    m_valid[IDW'(i)] = 1'b1;
                    m_data[i]   = {$urandom, $urandom};
                    m_key[i]    = {$urandom, $urandom};
                    m_mode[i]   = 1'($urandom);
                    m_verify[i] = 1'($urandom);
                end
                set_req(i, m_data[i], m_key[i], m_mode[i], m_verify[i]);
            end
            bus.req_valid_in         = m_valid;
            core_rdy                 = ($urandom_range(0, 4) != 0);
            rsp_rdy                  = ($urandom_range(0, 2) != 0);
            bus.des_encrypt_ready_in = core_rdy;
            bus.rsp_ready_in         = rsp_rdy;
            bus.des_result_valid_in  = (cyc == strobe_cyc);
            bus.des_result_in        = (cyc == strobe_cyc) ? res_val : {$urandom, $urandom};
            #1;

            found = 1'b0;
            win   = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (last + k) % N;
                if (!found && m_valid[IDW'(idx)]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            exp_rr = '0;
            if (!busy && core_rdy && found) exp_rr[IDW'(win)] = 1'b1;
            check("r_ready", 64'(bus.req_ready_out), 64'(exp_rr));
            check("r_enc", 64'(bus.des_encrypt_valid_out), 64'(busy && cyc == enc_cyc));
            if (busy && cyc == enc_cyc) begin
                check("r_data",   bus.des_data_out,          j_data);
                check("r_key",    bus.des_key_out,           j_key);
                check("r_mode",   64'(bus.des_mode_out),     64'(j_mode));
                check("r_verify", 64'(bus.des_verify_out),   64'(j_verify));
            end
            in_resp = busy && (cyc >= resp_start);
            check("r_rspv", 64'(bus.rsp_valid_out), 64'(in_resp));
            if (in_resp) begin
                check("r_rspid", 64'(bus.rsp_id_out),  64'(j_id));
                check("r_rspd",  bus.rsp_data_out,     exp_rdata);
                check("r_rspe",  64'(bus.rsp_err_out), 64'(exp_err));
            end

            if (busy && cyc == enc_cyc) begin
                dly        = $urandom_range(1, 19);
                strobe_cyc = cyc + dly;
                res_val    = {$urandom, $urandom};
                if (dly <= int'(TO)) begin
                    resp_start = strobe_cyc + 1;
                    exp_rdata  = res_val;
                    exp_err    = 1'b0;
                end else begin
                    resp_start = cyc + int'(TO) + 1;
                    exp_rdata  = '0;
                    exp_err    = 1'b1;
                end
            end
            if (in_resp && rsp_rdy) begin
                busy = 1'b0;
            end else if (exp_rr != '0) begin
                busy       = 1'b1;
                enc_cyc    = cyc + 1;
                resp_start = NEVER;
                last       = win;
                j_id       = win;
                j_data     = m_data[win];
                j_key      = m_key[win];
                j_mode     = m_mode[win];
                j_verify   = m_verify[win];
                m_valid[IDW'(win)] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
